// File: rtl/wb_dsp_master_if.sv
// wb_dsp_master_if: command/response handshake and Wishbone bus signals of the wb_dsp master
interface wb_dsp_master_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [aw-1:0] cmd_adr;
    logic [dw-1:0] cmd_dat;
    logic [3:0]    cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [dw-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic [aw-1:0] wb_adr_o;
    logic [dw-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [dw-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_status,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );
endinterface

// File: rtl/wb_dsp_master.sv
// wb_dsp_master: single-transfer Wishbone classic initiator with retry handling; WB_DSP_MASTER_TIMEOUT_EN adds a bus timeout
module wb_dsp_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 255
) (
    input logic            wb_clk,
    input logic            wb_rst,
    wb_dsp_master_if.master bus
);
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    // RST exists so cmd_ready stays low during reset and rises on the first edge after release
    typedef enum logic [2:0] {RST, IDLE, BUS, BACKOFF, RESP} state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [dw-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]    status_q, status_d;
    logic [RW-1:0] retry_q, retry_d;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
    localparam int TW = TIMEOUT > 255 ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign bus.cmd_ready  = state_q == IDLE;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dat    = rsp_dat_q;
    assign bus.rsp_status = status_q;
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.wb_sel_o   = sel_q;
    assign bus.wb_we_o    = we_q;
    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = cyc_q;
    assign bus.wb_cti_o   = 3'b000;
    assign bus.wb_bte_o   = 2'b00;

    // Next-state and registered-output decode; terminations prioritised err > ack > rty
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        status_d    = status_q;
        retry_d     = retry_q;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            RST: state_d = IDLE;
            IDLE: if (bus.cmd_valid) begin
                adr_d   = bus.cmd_adr;
                dat_d   = bus.cmd_dat;
                sel_d   = bus.cmd_sel;
                we_d    = bus.cmd_we;
                cyc_d   = 1'b1;
                retry_d = '0;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = BUS;
            end
            BUS: if (bus.wb_err_i) begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = '0;
                status_d    = 2'b01;
                state_d     = RESP;
            end else if (bus.wb_ack_i) begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = we_q ? '0 : bus.wb_dat_i;
                status_d    = 2'b00;
                state_d     = RESP;
            end else if (bus.wb_rty_i) begin
                cyc_d = 1'b0;
                if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = BACKOFF;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    status_d    = 2'b10;
                    state_d     = RESP;
                end
            end
`ifdef WB_DSP_MASTER_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = '0;
                status_d    = 2'b11;
                state_d     = RESP;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
`endif
            BACKOFF: begin
                cyc_d   = 1'b1;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = BUS;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transfer silently
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q     <= RST;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            status_q    <= '0;
            retry_q     <= '0;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            status_q    <= status_d;
            retry_q     <= retry_d;
`ifdef WB_DSP_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_dsp_master.sv
// tb_wb_dsp_master: directed scoreboard bench for wb_dsp_master with a configurable Wishbone slave model
module tb_wb_dsp_master;
    logic wb_clk = 1'b0;
    logic wb_rst = 1'b0;
    always #5 wb_clk = ~wb_clk;

    wb_dsp_master_if #(.dw(32), .aw(32)) bus();

    wb_dsp_master #(.dw(32), .aw(32), .MAX_RETRY(4), .TIMEOUT(16)) dut (
        .wb_clk(wb_clk),
        .wb_rst(wb_rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] d;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int rty_n = 0;
    int mode = 0;
    int base = 0;
    int nstb = 0;
    int cyc_cnt = 0;
    int c0 = 0;
    int unstable = 0;
    int lat;
    logic stb_p = 1'b0;
    logic [68:0] snap = '0;
    logic first;
    int idx;

    assign first = bus.wb_stb_o & ~stb_p;
    assign idx = nstb - base;

    // Slave: answers each new strobe one cycle later; rty for the first rty_n strobes, then per mode (0 ack, 1 err+ack, 2 silent)
    always @(posedge wb_clk) begin
        stb_p <= bus.wb_stb_o;
        cyc_cnt <= cyc_cnt + int'(bus.wb_cyc_o);
        if (first) nstb <= nstb + 1;
        bus.wb_rty_i <= first && idx < rty_n;
        bus.wb_ack_i <= first && idx >= rty_n && mode != 2;
        bus.wb_err_i <= first && idx >= rty_n && mode == 1;
        if (bus.wb_stb_o && stb_p && {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o} != snap)
            unstable <= unstable + 1;
        snap <= {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int n;
        @(negedge wb_clk);
        base = nstb;
        c0 = cyc_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_we = we;
        bus.cmd_adr = adr;
        bus.cmd_dat = dat;
        bus.cmd_sel = sel;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        chk("cmd_accept", {63'd0, bus.cmd_ready}, 64'd1);
        @(posedge wb_clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int l);
        l = 0;
        do begin
            @(posedge wb_clk);
            #1 l++;
        end while (!bus.rsp_valid && l < 300);
        chk("rsp_seen", {63'd0, bus.rsp_valid}, 64'd1);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        e = sbq.pop_front();
        chk({tag, "_status"}, {62'd0, bus.rsp_status}, {62'd0, e.st});
        chk({tag, "_dat"}, {32'd0, bus.rsp_dat}, {32'd0, e.d});
    endtask

    task automatic consume();
        @(negedge wb_clk);
        bus.rsp_ready = 1'b1;
        @(posedge wb_clk);
        #1 bus.rsp_ready = 1'b0;
        chk("rsp_dropped", {63'd0, bus.rsp_valid}, 64'd0);
        chk("ready_after", {63'd0, bus.cmd_ready}, 64'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_adr = '0;
        bus.cmd_dat = '0;
        bus.cmd_sel = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_dat_i = 32'h1234_5678;
        #12;
        chk("rst_ready", {63'd0, bus.cmd_ready}, 64'd0);
        chk("rst_cyc", {63'd0, bus.wb_cyc_o}, 64'd0);
        chk("rst_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        chk("cti_bte", {59'd0, bus.wb_cti_o, bus.wb_bte_o}, 64'd0);
        @(negedge wb_clk) wb_rst = 1'b1;
        @(posedge wb_clk);
        #1 chk("ready_release", {63'd0, bus.cmd_ready}, 64'd1);

        // write with one-cycle ack
        bus.rsp_ready = 1'b1;
        @(posedge wb_clk);
        #1 bus.rsp_ready = 1'b0;
        chk("idle_rsp_ready", {63'd0, bus.rsp_valid}, 64'd0);
        rty_n = 0;
        mode = 0;
        sbq.push_back('{2'b00, 32'd0});
        send(1'b1, 32'h9000_0004, 32'hDEAD_BEEF, 4'hF);
        chk("wr_bus", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o},
            {1'b1, 1'b1, 1'b1, 4'hF, 32'h9000_0004});
        chk("wr_dat", {32'd0, bus.wb_dat_o}, {32'd0, 32'hDEAD_BEEF});
        chk("busy_ready", {63'd0, bus.cmd_ready}, 64'd0);
        wait_rsp(lat);
        chk("wr_lat", 64'(lat), 64'd2);
        chk("wr_cyc_cycles", 64'(cyc_cnt - c0), 64'd2);
        chk("rsp_cyc_low", {63'd0, bus.wb_cyc_o}, 64'd0);
        check_rsp("wr");
        consume();

        // read held for three cycles before being taken
        sbq.push_back('{2'b00, 32'h1234_5678});
        send(1'b0, 32'h9000_0008, 32'h0, 4'hF);
        wait_rsp(lat);
        chk("rd_lat", 64'(lat), 64'd2);
        repeat (3) begin
            @(posedge wb_clk);
            #1 chk("rd_hold", {31'd0, bus.rsp_valid, bus.rsp_dat}, {31'd0, 1'b1, 32'h1234_5678});
        end
        check_rsp("rd");
        consume();

        // two retries then ack
        rty_n = 2;
        sbq.push_back('{2'b00, 32'd0});
        send(1'b1, 32'h9000_0010, 32'hA5A5_0001, 4'h3);
        wait_rsp(lat);
        chk("rty2_lat", 64'(lat), 64'd8);
        chk("rty2_strobes", 64'(nstb - base), 64'd3);
        chk("rty2_cyc_cycles", 64'(cyc_cnt - c0), 64'd6);
        check_rsp("rty2");
        consume();

        // retries exhausted
        rty_n = 100;
        sbq.push_back('{2'b10, 32'd0});
        send(1'b0, 32'h9000_0014, 32'h0, 4'hF);
        wait_rsp(lat);
        chk("rtyx_lat", 64'(lat), 64'd14);
        chk("rtyx_strobes", 64'(nstb - base), 64'd5);
        check_rsp("rtyx");
        consume();

        // err and ack together on a read
        rty_n = 0;
        mode = 1;
        sbq.push_back('{2'b01, 32'd0});
        send(1'b0, 32'h9000_0018, 32'h0, 4'hF);
        wait_rsp(lat);
        check_rsp("err");
        consume();

        // asynchronous reset in the middle of a bus cycle
        mode = 2;
        send(1'b0, 32'h9000_001C, 32'h0, 4'hF);
        @(posedge wb_clk);
        #1 chk("pre_rst_cyc", {63'd0, bus.wb_cyc_o}, 64'd1);
        #2 wb_rst = 1'b0;
        #1 chk("async_drop", {61'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid}, 64'd0);
        chk("async_ready", {63'd0, bus.cmd_ready}, 64'd0);
        @(negedge wb_clk) wb_rst = 1'b1;
        repeat (4) @(posedge wb_clk);
        #1 chk("no_rsp_after_rst", {62'd0, bus.rsp_valid, bus.wb_cyc_o}, 64'd0);
        mode = 0;
        sbq.push_back('{2'b00, 32'h1234_5678});
        send(1'b0, 32'h9000_0020, 32'h0, 4'hF);
        wait_rsp(lat);
        chk("post_rst_lat", 64'(lat), 64'd2);
        check_rsp("post_rst");
        consume();

`ifdef WB_DSP_MASTER_TIMEOUT_EN
        // silent slave aborted by the timeout
        mode = 2;
        sbq.push_back('{2'b11, 32'd0});
        send(1'b0, 32'h9000_0024, 32'h0, 4'hF);
        wait_rsp(lat);
        chk("tmo_lat", 64'(lat), 64'd16);
        chk("tmo_cyc_cycles", 64'(cyc_cnt - c0), 64'd16);
        check_rsp("tmo");
        consume();
`endif

        chk("stable_during_stb", 64'(unstable), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
